pong_sprite_compositor: RTL and testbench

Parametrised, pipelined successor of the Pong display controller. Composites NUM_SPRITES rectangular objects (walls, ball, paddles, score markers) against the VGA pixel stream and produces a registered pixel value, a per-sprite hit mask and a per-frame collision flag. Object geometry is written into a shadow bank at any time and becomes active only at the frame boundary, which keeps frames tear-free. Sits between the game-logic FSM and the VGA timing generator.

---
 rtl/pong_sprite_compositor.sv | 178 +++++++++++++++++
 tb/tb_pong_sprite_compositor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_sprite_compositor.sv
// Composites NUM_SPRITES double-buffered rectangles onto the pixel stream; flags per-frame overlaps.
// Latency: 2 cycles from xpix/ypix/pix_valid to pixval/hit_mask/pix_valid_out.
// Backpressure: none; one pixel is accepted every cycle and geometry writes are always taken.
module pong_sprite_compositor #(
    parameter int COORD_W     = 10,
    parameter int SIZE_W      = 8,
    parameter int NUM_SPRITES = 6,
    parameter int IDX_W       = 3,
    parameter int BLINK_BIT   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [COORD_W-1:0]     wr_x,
    input  logic [COORD_W-1:0]     wr_y,
    input  logic [SIZE_W-1:0]      wr_w,
    input  logic [SIZE_W-1:0]      wr_h,
    input  logic                   wr_vis,
    input  logic                   wr_blink,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     xpix,
    input  logic [COORD_W-1:0]     ypix,
    output logic                   pixval,
    output logic                   pix_valid_out,
    output logic [NUM_SPRITES-1:0] hit_mask,
    output logic                   collision
);

    // Shadow bank: written by game logic at any time.
    logic [COORD_W-1:0] sh_x_q     [NUM_SPRITES];
    logic [COORD_W-1:0] sh_y_q     [NUM_SPRITES];
    logic [SIZE_W-1:0]  sh_w_q     [NUM_SPRITES];
    logic [SIZE_W-1:0]  sh_h_q     [NUM_SPRITES];
    logic               sh_vis_q   [NUM_SPRITES];
    logic               sh_blink_q [NUM_SPRITES];

    // Active bank: what the compare stage actually sees; changes only at frame_start.
    logic [COORD_W-1:0] act_x_q     [NUM_SPRITES];
    logic [COORD_W-1:0] act_y_q     [NUM_SPRITES];
    logic [SIZE_W-1:0]  act_w_q     [NUM_SPRITES];
    logic [SIZE_W-1:0]  act_h_q     [NUM_SPRITES];
    logic               act_vis_q   [NUM_SPRITES];
    logic               act_blink_q [NUM_SPRITES];

    // Stage 1 pixel registers.
    logic               s1_vld_q;
    logic [COORD_W-1:0] s1_x_q;
    logic [COORD_W-1:0] s1_y_q;

    // Stage 2 (output) registers.
    logic [NUM_SPRITES-1:0] hit_d;
    logic [NUM_SPRITES-1:0] hit_q;
    logic                   pixval_q;
    logic                   vld2_q;
    logic                   multi_hit_c;

    // Frame-level state.
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       coll_acc_q, coll_acc_d;
    logic       collision_q, collision_d;

    // Shadow write; out-of-range indices match no slot and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x_q[i]     <= '0;
                sh_y_q[i]     <= '0;
                sh_w_q[i]     <= '0;
                sh_h_q[i]     <= '0;
                sh_vis_q[i]   <= 1'b0;
                sh_blink_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_en && ({1'b0, wr_idx} == (IDX_W+1)'(i))) begin
                    sh_x_q[i]     <= wr_x;
                    sh_y_q[i]     <= wr_y;
                    sh_w_q[i]     <= wr_w;
                    sh_h_q[i]     <= wr_h;
                    sh_vis_q[i]   <= wr_vis;
                    sh_blink_q[i] <= wr_blink;
                end
            end
        end
    end

    // Frame-boundary copy; takes pre-write shadow values, so a same-cycle write lands a frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                act_x_q[i]     <= '0;
                act_y_q[i]     <= '0;
                act_w_q[i]     <= '0;
                act_h_q[i]     <= '0;
                act_vis_q[i]   <= 1'b0;
                act_blink_q[i] <= 1'b0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                act_x_q[i]     <= sh_x_q[i];
                act_y_q[i]     <= sh_y_q[i];
                act_w_q[i]     <= sh_w_q[i];
                act_h_q[i]     <= sh_h_q[i];
                act_vis_q[i]   <= sh_vis_q[i];
                act_blink_q[i] <= sh_blink_q[i];
            end
        end
    end

    // Rectangle compare against the stage-1 pixel; ends are computed one bit wider so edge sprites never wrap.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit_d[i] = s1_vld_q
                && act_vis_q[i]
                && (!act_blink_q[i] || !frame_cnt_q[BLINK_BIT])
                && ({1'b0, s1_x_q} >= {1'b0, act_x_q[i]})
                && ({1'b0, s1_x_q} <  ({1'b0, act_x_q[i]} + (COORD_W+1)'(act_w_q[i])))
                && ({1'b0, s1_y_q} >= {1'b0, act_y_q[i]})
                && ({1'b0, s1_y_q} <  ({1'b0, act_y_q[i]} + (COORD_W+1)'(act_h_q[i])));
        end
    end

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign multi_hit_c = (hit_d & (hit_d - NUM_SPRITES'(1))) != '0;

    // Frame counter and collision accumulate/latch; a hit in the frame_start cycle still counts for the closing frame.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        coll_acc_d  = coll_acc_q | multi_hit_c;
        collision_d = collision_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            collision_d = coll_acc_q | multi_hit_c;
            coll_acc_d  = 1'b0;
        end
    end

    // Frame-level state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
            coll_acc_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            coll_acc_q  <= coll_acc_d;
            collision_q <= collision_d;
        end
    end

    // Two-stage pixel pipeline: register inputs, then register compare results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            hit_q    <= '0;
            pixval_q <= 1'b0;
            vld2_q   <= 1'b0;
        end else begin
            s1_vld_q <= pix_valid;
            s1_x_q   <= xpix;
            s1_y_q   <= ypix;
            hit_q    <= hit_d;
            pixval_q <= |hit_d;
            vld2_q   <= s1_vld_q;
        end
    end

    assign pixval        = pixval_q;
    assign pix_valid_out = vld2_q;
    assign hit_mask      = hit_q;
    assign collision     = collision_q;

endmodule

// File: tb/tb_pong_sprite_compositor.sv
// Bench for pong_sprite_compositor: directed scenarios plus randomized streaming against a rectangle model.
// Latency: expects outputs two clocks after each pixel.
// Backpressure: none to model; the bench drives one pixel per cycle when streaming.
module tb_pong_sprite_compositor;

    localparam int CW = 10;
    localparam int SW = 8;
    localparam int NS = 6;
    localparam int IW = 3;
    localparam int BB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [CW-1:0] wr_x = '0, wr_y = '0;
    logic [SW-1:0] wr_w = '0, wr_h = '0;
    logic          wr_vis = 1'b0, wr_blink = 1'b0;
    logic          pix_valid = 1'b0;
    logic [CW-1:0] xpix = '0, ypix = '0;
    logic          pixval, pix_valid_out, collision;
    logic [NS-1:0] hit_mask;

    int checks = 0;
    int errors = 0;

    pong_sprite_compositor #(
        .COORD_W(CW), .SIZE_W(SW), .NUM_SPRITES(NS), .IDX_W(IW), .BLINK_BIT(BB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_w(wr_w), .wr_h(wr_h), .wr_vis(wr_vis), .wr_blink(wr_blink),
        .pix_valid(pix_valid), .xpix(xpix), .ypix(ypix),
        .pixval(pixval), .pix_valid_out(pix_valid_out),
        .hit_mask(hit_mask), .collision(collision)
    );

    always #5 clk = ~clk;

    // Reference model: plain rectangles with integer geometry.
    typedef struct {
        int x; int y; int w; int h; bit vis; bit blink;
    } spr_t;

    spr_t m_sh  [NS];
    spr_t m_act [NS];
    int   m_fcnt = 0;
    bit   m_acc  = 0;
    bit   m_coll = 0;

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_sh[i]  = '{0, 0, 0, 0, 1'b0, 1'b0};
            m_act[i] = '{0, 0, 0, 0, 1'b0, 1'b0};
        end
        m_fcnt = 0; m_acc = 0; m_coll = 0;
    endfunction

    function automatic void model_frame();
        for (int i = 0; i < NS; i++) m_act[i] = m_sh[i];
        m_fcnt = (m_fcnt + 1) % 256;
        m_coll = m_acc;
        m_acc  = 0;
    endfunction

    function automatic logic [NS-1:0] ref_hits(input int px, input int py);
        logic [NS-1:0] r = '0;
        for (int i = 0; i < NS; i++) begin
            bit shown = m_act[i].vis && (!m_act[i].blink || ((m_fcnt / (1 << BB)) % 2) == 0);
            if (shown && px >= m_act[i].x && px < m_act[i].x + m_act[i].w &&
                py >= m_act[i].y && py < m_act[i].y + m_act[i].h)
                r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic do_write(input int idx, input int x, input int y, input int w, input int h,
                            input bit vis, input bit blink, input bit with_frame);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_x = CW'(x); wr_y = CW'(y);
        wr_w = SW'(w); wr_h = SW'(h); wr_vis = vis; wr_blink = blink;
        frame_start = with_frame;
        @(posedge clk); #1;
        wr_en = 1'b0; frame_start = 1'b0;
        if (with_frame) model_frame();
        if (idx < NS) m_sh[idx] = '{x, y, w, h, vis, blink};
    endtask

    task automatic do_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        model_frame();
    endtask

    // Presents one pixel, returns what came out one and two clocks later plus the model's mask.
    task automatic scan(input int px, input int py, output logic pv, output logic [NS-1:0] hm,
                        output logic vo, output logic vo_early, output logic [NS-1:0] exp);
        @(negedge clk);
        pix_valid = 1'b1; xpix = CW'(px); ypix = CW'(py);
        exp = ref_hits(px, py);
        if ($countones(exp) >= 2) m_acc = 1;
        @(posedge clk); @(negedge clk);
        pix_valid = 1'b0;
        vo_early = pix_valid_out;
        @(posedge clk); @(negedge clk);
        pv = pixval; hm = hit_mask; vo = pix_valid_out;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (pixval !== 1'b0) begin errors++; $display("FAIL reset_pixval: got %0b want 0", pixval); end
        checks++; if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b want 0", pix_valid_out); end
        checks++; if (hit_mask !== '0) begin errors++; $display("FAIL reset_mask: got %b want 0", hit_mask); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_coll: got %0b want 0", collision); end
    endtask

    task automatic test_basic();
        logic pv, vo, ve; logic [NS-1:0] hm, ex;
        do_write(0, 100, 50, 8, 8, 1'b1, 1'b0, 1'b0);
        do_frame();
        scan(100, 50, pv, hm, vo, ve, ex);
        checks++; if (ve !== 1'b0) begin errors++; $display("FAIL basic_latency: vld at t+1=%0b want 0", ve); end
        checks++; if (vo !== 1'b1) begin errors++; $display("FAIL basic_vld: got %0b want 1", vo); end
        checks++; if (hm !== ex) begin errors++; $display("FAIL basic_mask: got %b want %b", hm, ex); end
        checks++; if (pv !== |ex) begin errors++; $display("FAIL basic_pix_in: got %0b want %0b", pv, |ex); end
        scan(108, 50, pv, hm, vo, ve, ex);
        checks++; if (pv !== |ex) begin errors++; $display("FAIL basic_pix_out: got %0b want %0b", pv, |ex); end
    endtask

    task automatic test_shadow();
        logic pv, vo, ve; logic [NS-1:0] hm, ex;
        do_write(0, 200, 50, 8, 8, 1'b1, 1'b0, 1'b0);
        scan(100, 50, pv, hm, vo, ve, ex);
        checks++; if (pv !== |ex) begin errors++; $display("FAIL shadow_old_pre: got %0b want %0b", pv, |ex); end
        do_frame();
        scan(100, 50, pv, hm, vo, ve, ex);
        checks++; if (pv !== |ex) begin errors++; $display("FAIL shadow_old_post: got %0b want %0b", pv, |ex); end
        scan(200, 50, pv, hm, vo, ve, ex);
        checks++; if (hm !== ex) begin errors++; $display("FAIL shadow_new_post: got %b want %b", hm, ex); end
        // Write coinciding with frame_start shows only after the following pulse.
        do_write(0, 300, 50, 8, 8, 1'b1, 1'b0, 1'b1);
        scan(200, 50, pv, hm, vo, ve, ex);
        checks++; if (hm !== ex) begin errors++; $display("FAIL shadow_same_cycle_old: got %b want %b", hm, ex); end
        scan(300, 50, pv, hm, vo, ve, ex);
        checks++; if (hm !== ex) begin errors++; $display("FAIL shadow_same_cycle_new_early: got %b want %b", hm, ex); end
        do_frame();
        scan(300, 50, pv, hm, vo, ve, ex);
        checks++; if (hm !== ex) begin errors++; $display("FAIL shadow_same_cycle_new: got %b want %b", hm, ex); end
    endtask

    task automatic test_edge();
        logic pv, vo, ve; logic [NS-1:0] hm, ex;
        do_write(1, 1020, 0, 8, 4, 1'b1, 1'b0, 1'b0);
        do_write(2, 500, 500, 0, 5, 1'b1, 1'b0, 1'b0);
        do_write(7, 0, 0, 50, 50, 1'b1, 1'b0, 1'b0);
        do_frame();
        scan(1023, 0, pv, hm, vo, ve, ex);
        checks++; if (hm !== ex) begin errors++; $display("FAIL edge_1023: got %b want %b", hm, ex); end
        for (int x = 0; x < 4; x++) begin
            scan(x, 0, pv, hm, vo, ve, ex);
            checks++; if (hm !== ex) begin errors++; $display("FAIL edge_wrap x=%0d: got %b want %b", x, hm, ex); end
        end
        scan(500, 500, pv, hm, vo, ve, ex);
        checks++; if (hm !== ex) begin errors++; $display("FAIL edge_w0: got %b want %b", hm, ex); end
    endtask

    task automatic test_collision();
        logic pv, vo, ve; logic [NS-1:0] hm, ex;
        for (int i = 0; i < NS; i++) do_write(i, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        do_write(3, 300, 200, 4, 4, 1'b1, 1'b0, 1'b0);
        do_write(4, 302, 190, 8, 40, 1'b1, 1'b0, 1'b0);
        do_frame();
        scan(302, 200, pv, hm, vo, ve, ex);
        checks++; if (hm !== ex) begin errors++; $display("FAIL coll_mask: got %b want %b", hm, ex); end
        do_frame();
        checks++; if (collision !== m_coll) begin errors++; $display("FAIL coll_set: got %0b want %0b", collision, m_coll); end
        scan(0, 0, pv, hm, vo, ve, ex);
        checks++; if (collision !== m_coll) begin errors++; $display("FAIL coll_hold: got %0b want %0b", collision, m_coll); end
        do_write(4, 400, 190, 8, 40, 1'b1, 1'b0, 1'b0);
        do_frame();
        scan(302, 200, pv, hm, vo, ve, ex);
        checks++; if (hm !== ex) begin errors++; $display("FAIL coll_ball_only: got %b want %b", hm, ex); end
        do_frame();
        checks++; if (collision !== m_coll) begin errors++; $display("FAIL coll_clear: got %0b want %0b", collision, m_coll); end
    endtask

    task automatic test_blink();
        logic pv, vo, ve; logic [NS-1:0] hm, ex;
        do_write(5, 10, 10, 2, 2, 1'b1, 1'b1, 1'b0);
        do_frame();
        for (int f = 0; f < 300; f++) begin
            scan(10, 10, pv, hm, vo, ve, ex);
            checks++;
            if (pv !== |ex) begin errors++; $display("FAIL blink fcnt=%0d: got %0b want %0b", m_fcnt, pv, |ex); end
            do_frame();
        end
    endtask

    task automatic test_back_to_back();
        logic [NS:0] exp_q [$];
        logic [NS:0] e;
        for (int i = 0; i < NS; i++)
            do_write(i, $urandom_range(0, 40), $urandom_range(0, 10), $urandom_range(0, 16),
                     $urandom_range(0, 8), ($urandom % 4) != 0, $urandom % 2, 1'b0);
        do_frame();
        for (int k = 0; k < 202; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                e = exp_q.pop_front();
                checks++;
                if (pix_valid_out !== e[NS] || hit_mask !== e[NS-1:0] || pixval !== |e[NS-1:0]) begin
                    errors++;
                    $display("FAIL stream k=%0d: vld=%0b mask=%b pix=%0b want vld=%0b mask=%b pix=%0b",
                             k, pix_valid_out, hit_mask, pixval, e[NS], e[NS-1:0], |e[NS-1:0]);
                end
            end
            if (k < 200) begin
                int px = $urandom_range(0, 63);
                int py = $urandom_range(0, 15);
                bit v  = ($urandom % 4) != 0;
                pix_valid = v; xpix = CW'(px); ypix = CW'(py);
                e = '0;
                if (v) begin
                    e[NS-1:0] = ref_hits(px, py);
                    e[NS] = 1'b1;
                    if ($countones(e[NS-1:0]) >= 2) m_acc = 1;
                end
                exp_q.push_back(e);
            end else begin
                pix_valid = 1'b0;
            end
        end
        do_frame();
        checks++; if (collision !== m_coll) begin errors++; $display("FAIL stream_coll: got %0b want %0b", collision, m_coll); end
    endtask

    task automatic test_async_reset();
        logic pv, vo, ve; logic [NS-1:0] hm, ex;
        do_write(0, 20, 5, 30, 6, 1'b1, 1'b0, 1'b0);
        do_frame();
        @(negedge clk);
        pix_valid = 1'b1; xpix = CW'(25); ypix = CW'(7);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (pixval !== 1'b0) begin errors++; $display("FAIL areset_pixval: got %0b want 0", pixval); end
        checks++; if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL areset_vld: got %0b want 0", pix_valid_out); end
        checks++; if (hit_mask !== '0) begin errors++; $display("FAIL areset_mask: got %b want 0", hit_mask); end
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL areset_coll: got %0b want 0", collision); end
        @(negedge clk);
        pix_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        scan(25, 7, pv, hm, vo, ve, ex);
        checks++; if (pv !== |ex) begin errors++; $display("FAIL areset_blank: got %0b want %0b", pv, |ex); end
        do_frame();
        scan(25, 7, pv, hm, vo, ve, ex);
        checks++; if (pv !== |ex) begin errors++; $display("FAIL areset_blank_frame: got %0b want %0b", pv, |ex); end
        do_write(0, 20, 5, 30, 6, 1'b1, 1'b0, 1'b0);
        do_frame();
        scan(25, 7, pv, hm, vo, ve, ex);
        checks++; if (hm !== ex) begin errors++; $display("FAIL areset_restore: got %b want %b", hm, ex); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shadow();
        test_edge();
        test_collision();
        test_blink();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
